// File: rtl/result_to_bcd.sv
// result_to_bcd: sequential two's-complement / unsigned byte to sign + 3-digit BCD converter.
// Captures din on start, runs 8 shift-add-3 steps, then publishes digits with a done pulse.

module result_to_bcd #(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic       neg,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] units
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFinish
    } state_t;

    state_t      state;
    logic [19:0] sr;       // {hundreds, tens, units, magnitude}
    logic [2:0]  cnt;
    logic        sign;

    logic        cap_neg;
    logic [8:0]  mag9;
    logic [7:0]  cap_mag;
    logic [19:0] adj;

    // Sign and magnitude of the incoming operand; 9-bit negate keeps -128 -> 128.
    always_comb begin
        cap_neg = SIGNED_IN && din[7];
        mag9    = {1'b0, din};
        if (cap_neg) begin
            mag9 = {1'b0, ~din} + 9'd1;
        end
        cap_mag = mag9[7:0];
    end

    // Add 3 to every BCD nibble that is 5 or more; nibbles do not carry into each other.
    always_comb begin
        adj = sr;
        for (int i = 0; i < 3; i++) begin
            if (sr[8 + 4*i +: 4] >= 4'd5) begin
                adj[8 + 4*i +: 4] = sr[8 + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            sr    <= '0;
            cnt   <= '0;
            sign  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            neg   <= 1'b0;
            hund  <= '0;
            tens  <= '0;
            units <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        sr    <= {12'd0, cap_mag};
                        sign  <= cap_neg;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= StShift;
                    end
                end
                StShift: begin
                    sr  <= {adj[18:0], 1'b0};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= StFinish;
                    end
                end
                StFinish: begin
                    hund  <= sr[19:16];
                    tens  <= sr[15:12];
                    units <= sr[11:8];
                    neg   <= sign;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_to_bcd.sv
// Scoreboard bench for result_to_bcd: one signed and one unsigned instance share stimulus.

module tb_result_to_bcd;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] din;

    logic       busy_s, done_s, neg_s;
    logic [3:0] hund_s, tens_s, units_s;
    logic       busy_u, done_u, neg_u;
    logic [3:0] hund_u, tens_u, units_u;

    result_to_bcd #(.SIGNED_IN(1'b1)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (din),
        .busy  (busy_s),
        .done  (done_s),
        .neg   (neg_s),
        .hund  (hund_s),
        .tens  (tens_s),
        .units (units_s)
    );

    result_to_bcd #(.SIGNED_IN(1'b0)) dut_u (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (din),
        .busy  (busy_u),
        .done  (done_u),
        .neg   (neg_u),
        .hund  (hund_u),
        .tens  (tens_u),
        .units (units_u)
    );

    typedef struct {
        logic [12:0] res;  // {neg, hund, tens, units}
        int          cyc;  // negedge count at which done must be seen
    } exp_t;

    exp_t q_s[$];
    exp_t q_u[$];
    int   cyc;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // Independent reference: decimal arithmetic on the interpreted value.
    function automatic logic [12:0] model(input logic [7:0] d, input bit sgn);
        int v;
        int m;
        logic [12:0] r;
        v = sgn ? int'($signed(d)) : int'(d);
        m = (v < 0) ? -v : v;
        r[12]    = (v < 0);
        r[11:8]  = 4'(m / 100);
        r[7:4]   = 4'((m / 10) % 10);
        r[3:0]   = 4'(m % 10);
        return r;
    endfunction

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per done pulse and compare digits and timing.
    always @(negedge clk) begin
        if (rst_n && done_s) begin
            checks++;
            if (q_s.size() == 0) begin
                errors++;
                $display("FAIL signed unexpected done at cyc %0d got %h", cyc,
                         {neg_s, hund_s, tens_s, units_s});
            end else begin
                exp_t e;
                e = q_s.pop_front();
                if ({neg_s, hund_s, tens_s, units_s} !== e.res || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL signed result: got %h at cyc %0d expected %h at cyc %0d",
                             {neg_s, hund_s, tens_s, units_s}, cyc, e.res, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done_u) begin
            checks++;
            if (q_u.size() == 0) begin
                errors++;
                $display("FAIL unsigned unexpected done at cyc %0d got %h", cyc,
                         {neg_u, hund_u, tens_u, units_u});
            end else begin
                exp_t e;
                e = q_u.pop_front();
                if ({neg_u, hund_u, tens_u, units_u} !== e.res || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL unsigned result: got %h at cyc %0d expected %h at cyc %0d",
                             {neg_u, hund_u, tens_u, units_u}, cyc, e.res, e.cyc);
                end
            end
        end
    end

    // Called on a negedge: present operand, pulse start, wait until done is visible.
    task automatic issue(input logic [7:0] d, input logic [12:0] es, input logic [12:0] eu);
        exp_t e;
        din   = d;
        start = 1'b1;
        e.cyc = cyc + 10;
        e.res = es;
        q_s.push_back(e);
        e.res = eu;
        q_u.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check_val({name, " signed"}, {7'd0, busy_s, done_s, neg_s, hund_s, tens_s, units_s}, 16'd0);
        check_val({name, " unsigned"}, {7'd0, busy_u, done_u, neg_u, hund_u, tens_u, units_u},
                  16'd0);
    endtask

    // Directed vectors: din, signed expectation, unsigned expectation {neg,h,t,u}.
    logic [7:0]  tab_din [6] = '{8'hFB, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01};
    logic [12:0] tab_s   [6] = '{13'h1005, 13'h1128, 13'h0127, 13'h0000, 13'h1001, 13'h0001};
    logic [12:0] tab_u   [6] = '{13'h0251, 13'h0128, 13'h0127, 13'h0000, 13'h0255, 13'h0001};

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        din    = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            issue(tab_din[i], tab_s[i], tab_u[i]);
        end

        // Operand change and start pulse during busy are ignored: single done with 0/4/2.
        begin
            exp_t e;
            din   = 8'h2A;
            start = 1'b1;
            e.cyc = cyc + 10;
            e.res = 13'h0042;
            q_s.push_back(e);
            q_u.push_back(e);
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            check_val("busy during conversion", {14'd0, busy_s, busy_u}, 16'h0003);
            @(negedge clk);
            din   = 8'h01;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (7) @(negedge clk);
            repeat (12) @(negedge clk);
        end

        // Leave nonzero outputs, then abort a conversion with reset at its fourth cycle.
        issue(8'hFF, 13'h1001, 13'h0255);
        din   = 8'hFB;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("async reset mid-conversion");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_zero("after aborted conversion");
        issue(8'hFB, 13'h1005, 13'h0251);

        // Exhaustive sweep with start held high: restart every 10 cycles.
        start = 1'b1;
        for (int v = 0; v < 256; v++) begin
            exp_t e;
            din   = 8'(v);
            e.cyc = cyc + 10;
            e.res = model(8'(v), 1'b1);
            q_s.push_back(e);
            e.res = model(8'(v), 1'b0);
            q_u.push_back(e);
            repeat (10) @(negedge clk);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        check_val("signed pending expectations", 16'(q_s.size()), 16'd0);
        check_val("unsigned pending expectations", 16'(q_u.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
